// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: bridges a req/gnt bus onto a single-port 32-bit SRAM bank
// and sequences the bank into and out of retention.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   req_i/gnt_o                     bus handshake (gnt_o combinational)
//   addr_i, we_i, be_i, wdata_i     bus request payload (byte address)
//   rvalid_o, rdata_o               one-cycle-latency response
//   ret_req_i, ret_ack_o            retention request / bank-retentive flag
//   sram_*                          SRAM macro interface
module sram_access_ctrl #(
  parameter int unsigned NumWords     = 8192,
  parameter int unsigned AddrWidth    = (NumWords <= 1) ? 1 : $clog2(NumWords),
  parameter int unsigned WakeupCycles = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  input  logic                 ret_req_i,
  output logic                 ret_ack_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  output logic                 sram_set_retentive_no,
  input  logic [31:0]          sram_rdata_i
);

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    StActive = 2'd0,
    StEnter  = 2'd1,
    StRet    = 2'd2,
    StWake   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wake_cnt_q, wake_cnt_d;
  logic            rvalid_q;
  logic            rd_q;
  logic            ret_ack_q;
  logic            ret_n_q;

  // Retention request wins over a same-cycle bus request.
  assign gnt_o = req_i & (state_q == StActive) & ~ret_req_i;

  // Straight pass-through to the macro; byte offset and high bits alias.
  assign sram_req_o   = gnt_o;
  assign sram_we_o    = we_i;
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = be_i;
  assign sram_addr_o  = addr_i[AddrWidth+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:AddrWidth+2], addr_i[1:0]};

  // Macro data is valid the cycle after a read; writes return zero data.
  assign rvalid_o = rvalid_q;
  assign rdata_o  = (rvalid_q & rd_q) ? sram_rdata_i : 32'h0;

  assign ret_ack_o             = ret_ack_q;
  assign sram_set_retentive_no = ret_n_q;

  // Retention sequencing: ENTER is a one-cycle drain slot before RET.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      StActive: begin
        if (ret_req_i) state_d = StEnter;
      end
      StEnter: begin
        state_d = ret_req_i ? StRet : StActive;
      end
      StRet: begin
        if (!ret_req_i) begin
          state_d    = StWake;
          wake_cnt_d = CntW'(WakeupCycles);
        end
      end
      StWake: begin
        // ret_req_i is deliberately not sampled until ACTIVE is reached.
        if (wake_cnt_q <= CntW'(1)) begin
          state_d    = StActive;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d    = StActive;
        wake_cnt_d = '0;
      end
    endcase
  end

  // All state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StActive;
      wake_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rd_q       <= 1'b0;
      ret_ack_q  <= 1'b0;
      ret_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      rvalid_q   <= gnt_o;
      rd_q       <= gnt_o & ~we_i;
      ret_ack_q  <= (state_d == StRet);
      ret_n_q    <= (state_d != StRet);
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed + randomized checks of sram_access_ctrl
// against a behavioural model (mode/wake countdown, expected memory image,
// one-deep response slot). A simple SRAM macro model backs the DUT.
module tb_sram_access_ctrl;

  localparam int unsigned NW = 8192;
  localparam int unsigned AW = 13;
  localparam int unsigned WK = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          req_i, gnt_o;
  logic [31:0]   addr_i;
  logic          we_i;
  logic [3:0]    be_i;
  logic [31:0]   wdata_i;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          ret_req_i, ret_ack_o;
  logic          sram_req_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic [3:0]    sram_be_o;
  logic          sram_set_retentive_no;
  logic [31:0]   sram_rdata_i;

  sram_access_ctrl #(.NumWords(NW), .WakeupCycles(WK)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .req_i                 (req_i),
    .gnt_o                 (gnt_o),
    .addr_i                (addr_i),
    .we_i                  (we_i),
    .be_i                  (be_i),
    .wdata_i               (wdata_i),
    .rvalid_o              (rvalid_o),
    .rdata_o               (rdata_o),
    .ret_req_i             (ret_req_i),
    .ret_ack_o             (ret_ack_o),
    .sram_req_o            (sram_req_o),
    .sram_we_o             (sram_we_o),
    .sram_addr_o           (sram_addr_o),
    .sram_wdata_o          (sram_wdata_o),
    .sram_be_o             (sram_be_o),
    .sram_set_retentive_no (sram_set_retentive_no),
    .sram_rdata_i          (sram_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // SRAM macro: synchronous, read data one cycle after the request.
  logic [31:0] mem [NW];
  initial begin
    for (int i = 0; i < int'(NW); i++) mem[i] = 32'h0;
    sram_rdata_i = 32'h0;
  end
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_ACT = 0, M_ENTER = 1, M_RET = 2, M_WAKE = 3;
  int          mode      = M_ACT;
  int          wake_left = 0;
  bit          pend_v    = 0;
  bit          pend_rd   = 0;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] exp_mem [int unsigned];
  bit          e_gnt;

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a / 4) % NW;
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned w);
    return exp_mem.exists(w) ? exp_mem[w] : 32'h0;
  endfunction

  // Compare all outputs mid-cycle against the model.
  task automatic mid();
    #4;
    e_gnt = req_i && (mode == M_ACT) && !ret_req_i;
    check("gnt", 32'(gnt_o), 32'(e_gnt));
    check("sram_req", 32'(sram_req_o), 32'(e_gnt));
    if (e_gnt) begin
      check("sram_addr", 32'(sram_addr_o), 32'(word_of(addr_i)));
      check("sram_we", 32'(sram_we_o), 32'(we_i));
      if (we_i) begin
        check("sram_wdata", sram_wdata_o, wdata_i);
        check("sram_be", 32'(sram_be_o), 32'(be_i));
      end
    end
    check("rvalid", 32'(rvalid_o), 32'(pend_v));
    check("rdata", rdata_o, (pend_v && pend_rd) ? pend_data : 32'h0);
    check("ret_ack", 32'(ret_ack_o), 32'(mode == M_RET));
    check("ret_n", 32'(sram_set_retentive_no), 32'(mode != M_RET));
  endtask

  // Advance model across the rising edge.
  task automatic edge_step();
    int unsigned w;
    logic [31:0] d;
    @(posedge clk_i);
    w       = word_of(addr_i);
    pend_v  = e_gnt;
    pend_rd = e_gnt && !we_i;
    if (e_gnt && !we_i) pend_data = mem_rd(w);
    if (e_gnt && we_i) begin
      d = mem_rd(w);
      for (int b = 0; b < 4; b++) if (be_i[b]) d[8*b +: 8] = wdata_i[8*b +: 8];
      exp_mem[w] = d;
    end
    case (mode)
      M_ACT:   if (ret_req_i) mode = M_ENTER;
      M_ENTER: mode = ret_req_i ? M_RET : M_ACT;
      M_RET:   if (!ret_req_i) begin mode = M_WAKE; wake_left = WK; end
      default: begin
        wake_left--;
        if (wake_left == 0) mode = M_ACT;
      end
    endcase
    #1;
  endtask

  task automatic cycle();
    mid();
    edge_step();
  endtask

  task automatic drive(input bit rq, input bit we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input bit rr);
    req_i = rq; we_i = we; addr_i = a; be_i = be; wdata_i = wd; ret_req_i = rr;
  endtask

  // Reset asserted away from the clock edge; effects must be immediate.
  task automatic do_reset();
    req_i  = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_ret_n", 32'(sram_set_retentive_no), 32'd1);
    check("rst_ret_ack", 32'(ret_ack_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    mode = M_ACT; wake_left = 0; pend_v = 0; pend_rd = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    int  zeros;
    bit  seen;
    bit  rr;
    rst_ni = 1'b0;
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
    @(posedge clk_i);
    #1;
    do_reset();

    // Write then read back through the same word.
    drive(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    mid(); check("t37_waddr", 32'(sram_addr_o), 32'd4); edge_step();
    drive(1, 0, 32'h10, 4'h0, 32'h0, 0);
    mid(); check("t37_raddr", 32'(sram_addr_o), 32'd4); edge_step();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
    mid(); check("t37_rvalid", 32'(rvalid_o), 32'd1);
    check("t37_rdata", rdata_o, 32'hDEADBEEF); edge_step();

    // Back-to-back reads deliver back-to-back data in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'(4 * i), 4'hF, 32'hA5A5_0000 + 32'(i), 0);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 0, 32'(4 * i), 4'h0, 32'h0, 0);
      else       drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
      mid();
      if (i > 0) begin
        check("t38_rvalid", 32'(rvalid_o), 32'd1);
        check("t38_rdata", rdata_o, 32'hA5A5_0000 + 32'(i - 1));
      end
      edge_step();
    end

    // Retention request beats a same-cycle bus request.
    drive(1, 0, 32'h0, 4'hF, 32'h0, 1);
    mid(); check("t39_gnt", 32'(gnt_o), 32'd0); edge_step();
    mid(); check("t39_enter_ack", 32'(ret_ack_o), 32'd0); edge_step();
    mid(); check("t39_ack", 32'(ret_ack_o), 32'd1);
    check("t39_ret_n", 32'(sram_set_retentive_no), 32'd0); edge_step();

    // Wake-up: count grant-less cycles after the release cycle.
    drive(1, 0, 32'h20, 4'hF, 32'h0, 0);
    cycle();
    zeros = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      mid();
      if (gnt_o) seen = 1; else zeros++;
      edge_step();
    end
    check("t40_seen", 32'(seen), 32'd1);
    check("t40_wait", 32'(zeros), 32'(WK));

    // One-cycle retention pulse never reaches RET.
    drive(0, 0, 32'h0, 4'h0, 32'h0, 1);
    cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
    mid(); check("t41_enter_ack", 32'(ret_ack_o), 32'd0); edge_step();
    drive(1, 0, 32'h4, 4'h0, 32'h0, 0);
    mid(); check("t41_ack", 32'(ret_ack_o), 32'd0);
    check("t41_gnt", 32'(gnt_o), 32'd1); edge_step();

    // Reset mid-WAKE: immediate exit, grant right after release.
    drive(0, 0, 32'h0, 4'h0, 32'h0, 1);
    for (int i = 0; i < 3; i++) cycle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
    cycle();
    cycle();
    do_reset();
    drive(1, 0, 32'h8, 4'h0, 32'h0, 0);
    mid(); check("t42_gnt", 32'(gnt_o), 32'd1); edge_step();

    // Reset with a read response pending drops it.
    do_reset();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
    mid(); check("t36_rvalid", 32'(rvalid_o), 32'd0); edge_step();

    // Randomized traffic with retention toggling and occasional resets.
    rr = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) rr = !rr;
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            $urandom & 32'hC000_003F, 4'($urandom), $urandom, rr);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter NumWords, default 8192: number of 32-bit words in the target SRAM bank.
REQ-002 Parameter AddrWidth, default clog2(NumWords) (1 if NumWords<=1): derived, SHALL NOT be overridden.
REQ-003 Parameter WakeupCycles, default 4: cycles waited after leaving retention; legal range 1..255.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  1  bus request.
REQ-007 gnt_o  output  1  bus grant (combinational).
REQ-008 addr_i  input  32  byte address.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 be_i  input  4  byte enables.
REQ-011 wdata_i  input  32  write data.
REQ-012 rvalid_o  output  1  response valid.
REQ-013 rdata_o  output  32  read data.
REQ-014 ret_req_i  input  1  request to enter retention; deassert to wake.
REQ-015 ret_ack_o  output  1  bank is in retention.
REQ-016 sram_req_o / sram_we_o  output  1 each  SRAM request / write enable, active-high.
REQ-017 sram_addr_o  output  AddrWidth  SRAM word address.
REQ-018 sram_wdata_o / sram_be_o  output  32 / 4  SRAM write data / byte enables.
REQ-019 sram_set_retentive_no  output  1  SRAM retention control, active-low.
REQ-020 sram_rdata_i  input  32  SRAM read data, valid one cycle after a read request.

Function
REQ-021 FSM states SHALL be ACTIVE, ENTER, RET and WAKE; reset state is ACTIVE.
REQ-022 gnt_o SHALL equal req_i AND (state==ACTIVE) AND NOT ret_req_i; retention has priority over new requests in the same cycle.
REQ-023 sram_req_o SHALL equal gnt_o; sram_we_o, sram_wdata_o and sram_be_o SHALL pass we_i, wdata_i and be_i through.
REQ-024 sram_addr_o SHALL equal addr_i[AddrWidth+1:2]; addr_i[1:0] and the bits above AddrWidth+1 SHALL be ignored (aliasing).
REQ-025 Each granted request SHALL produce exactly one rvalid_o pulse in the next cycle; latency is fixed at 1 and back-to-back grants give back-to-back rvalid_o.
REQ-026 During a read response, rdata_o SHALL equal sram_rdata_i; during a write response and when rvalid_o=0, rdata_o SHALL be 0.
REQ-027 ACTIVE->ENTER SHALL occur when ret_req_i=1.
REQ-028 ENTER lasts 1 cycle, which drains any outstanding response: go to RET if ret_req_i=1, else back to ACTIVE.
REQ-029 In RET, sram_set_retentive_no SHALL be 0 and ret_ack_o SHALL be 1; in all other states they SHALL be 1 and 0 respectively.
REQ-030 RET->WAKE SHALL occur when ret_req_i=0; on entry the wake counter SHALL load WakeupCycles.
REQ-031 WAKE SHALL last exactly WakeupCycles cycles, decrementing the counter, and then go to ACTIVE.
REQ-032 ret_req_i reasserted during WAKE SHALL be ignored until ACTIVE is reached; the block then goes to ENTER on the next cycle.
REQ-033 gnt_o SHALL be 0 in ENTER, RET and WAKE, so that no SRAM access occurs while the bank is retentive or waking.

Reset
REQ-034 When rst_ni=0, the following SHALL hold asynchronously: state=ACTIVE, wake counter=0, rvalid_o=0, rdata_o=0, ret_ack_o=0, sram_set_retentive_no=1.
REQ-035 Reset asserted during RET or WAKE SHALL immediately restore sram_set_retentive_no=1, with no wake-up wait after release.
REQ-036 Reset asserted with a response pending SHALL drop that response; no rvalid_o is produced after release.

Verification
REQ-037 Write 0xDEADBEEF at addr 0x10 with be=0xF, then read addr 0x10 -> sram_addr_o=4 on both accesses; the read gives rvalid_o 1 cycle later with rdata_o=0xDEADBEEF.
REQ-038 4 back-to-back reads at addrs 0x0,0x4,0x8,0xC -> 4 consecutive rvalid_o cycles, each delivering data in order.
REQ-039 req_i=1 and ret_req_i=1 in the same cycle -> gnt_o=0; ENTER, then RET, with ret_ack_o=1 and sram_set_retentive_no=0 two cycles later.
REQ-040 Release ret_req_i in RET with WakeupCycles=4 -> gnt_o=0 for exactly 4 cycles; the first grant is possible in cycle 5.
REQ-041 ret_req_i pulsed for 1 cycle -> ENTER then ACTIVE; RET is never entered and ret_ack_o stays 0.
REQ-042 rst_ni asserted mid-WAKE -> sram_set_retentive_no=1 and state=ACTIVE immediately; grant is available in the first cycle after release.
